// File: rtl/pc_next_ctrl_if.sv
// Bundle between the next-PC sequencer and the fetch stage / PC register.
// The pipeline side uses the master modport and the sequencer uses the slave modport.
interface pc_next_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pc_cur;
  logic             stall;
  logic             imem_ready;
  logic             jmp;
  logic [31:0]      jmp_target;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             exc;
  logic             pc_en;
  logic [31:0]      pc_addr;
  logic             flush_if;
  logic             flush_id;
  logic             redirect_pending;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output pc_cur, stall, imem_ready, jmp, jmp_target, br_taken, br_target, exc,
    input  pc_en, pc_addr, flush_if, flush_id, redirect_pending, redirect_cnt
  );

  modport slave (
    input  pc_cur, stall, imem_ready, jmp, jmp_target, br_taken, br_target, exc,
    output pc_en, pc_addr, flush_if, flush_id, redirect_pending, redirect_cnt
  );
endinterface

// File: rtl/pc_next_ctrl.sv
// Next-PC sequencer: chooses between PC+4, the ID jump, the EX branch and the exception vector,
// and holds a redirect in a pending buffer until instruction memory can accept it.
module pc_next_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0100,
  parameter int          CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  pc_next_ctrl_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  typedef enum logic [1:0] {K_NONE, K_JMP, K_BR, K_EXC} kind_t;

  state_t           state;
  kind_t            pend_kind;
  logic [31:0]      pend_addr;
  logic [CNT_W-1:0] cnt;

  logic        redir;
  logic        apply;
  logic [31:0] new_addr;
  kind_t       new_kind;

  always_comb begin
    redir                = 1'b0;
    apply                = 1'b0;
    new_addr             = pend_addr;
    new_kind             = pend_kind;
    bus.pc_en            = 1'b0;
    bus.pc_addr          = RESET_VEC;
    bus.flush_if         = 1'b0;
    bus.flush_id         = 1'b0;
    bus.redirect_pending = 1'b0;
    if (!rst) begin
      unique case (state)
        BOOT: bus.pc_addr = RESET_VEC;
        RUN: begin
          if (bus.exc) begin
            redir    = 1'b1;
            new_addr = EXC_VEC;
            new_kind = K_EXC;
          end else if (bus.br_taken) begin
            redir    = 1'b1;
            new_addr = bus.br_target;
            new_kind = K_BR;
          end else if (bus.jmp) begin
            redir    = 1'b1;
            new_addr = bus.jmp_target;
            new_kind = K_JMP;
          end
          if (redir) begin
            bus.flush_if = 1'b1;
            bus.flush_id = (new_kind != K_JMP);
            bus.pc_en    = bus.imem_ready;
            bus.pc_addr  = new_addr;
            apply        = bus.imem_ready;
          end else begin
            bus.pc_en   = bus.imem_ready & ~bus.stall;
            bus.pc_addr = bus.pc_cur + 32'd4;
          end
        end
        PEND: begin
          // A later jmp is on the wrong path; only an exception or an older branch may override.
          bus.redirect_pending = 1'b1;
          bus.flush_if         = 1'b1;
          if (bus.exc) begin
            new_addr     = EXC_VEC;
            new_kind     = K_EXC;
            bus.flush_id = 1'b1;
          end else if (bus.br_taken && pend_kind == K_JMP) begin
            new_addr     = bus.br_target;
            new_kind     = K_BR;
            bus.flush_id = 1'b1;
          end
          bus.pc_en   = bus.imem_ready;
          bus.pc_addr = new_addr;
          apply       = bus.imem_ready;
        end
        default: bus.pc_addr = RESET_VEC;
      endcase
    end
    bus.pc_addr[1:0] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pend_addr <= RESET_VEC;
      pend_kind <= K_NONE;
      cnt       <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redir && !bus.imem_ready) begin
            pend_addr <= new_addr;
            pend_kind <= new_kind;
            state     <= PEND;
          end
        end
        PEND: begin
          if (bus.imem_ready) begin
            pend_kind <= K_NONE;
            state     <= RUN;
          end else begin
            pend_addr <= new_addr;
            pend_kind <= new_kind;
          end
        end
        default: state <= BOOT;
      endcase
      if (apply && cnt != '1)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.redirect_cnt = cnt;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl, built with a 2-bit redirect counter so saturation is reachable.
module tb_pc_next_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pc_next_ctrl_if #(.CNT_W(2)) ifc ();

  pc_next_ctrl #(
    .RESET_VEC(32'h0000_0000),
    .EXC_VEC  (32'h0000_0100),
    .CNT_W    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after a rising edge, then waits for the falling edge to sample.
  task automatic applyStimulus(input logic [31:0] pc, input logic st, input logic im,
                               input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt, input logic e);
    ifc.pc_cur     = pc;
    ifc.stall      = st;
    ifc.imem_ready = im;
    ifc.jmp        = j;
    ifc.jmp_target = jt;
    ifc.br_taken   = b;
    ifc.br_target  = bt;
    ifc.exc        = e;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    checkOutput("rst_pc_en", 32'(ifc.pc_en), 32'd0);
    checkOutput("rst_pc_addr", ifc.pc_addr, 32'h0);
    checkOutput("rst_flush_if", 32'(ifc.flush_if), 32'd0);
    checkOutput("rst_flush_id", 32'(ifc.flush_id), 32'd0);
    checkOutput("rst_pending", 32'(ifc.redirect_pending), 32'd0);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    checkOutput("rst_cnt", 32'(ifc.redirect_cnt), 32'd0);
    tick();

    rst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("boot_pc_en", 32'(ifc.pc_en), 32'd0);
    checkOutput("boot_flush_if", 32'(ifc.flush_if), 32'd0);
    tick();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("seq_pc_en", 32'(ifc.pc_en), 32'd1);
      checkOutput("seq_pc_addr", ifc.pc_addr, 32'((i + 1) * 4));
      tick();
    end
    applyStimulus(32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("boot_jmp_ignored_cnt", 32'(ifc.redirect_cnt), 32'd0);
    checkOutput("imem_busy_pc_en", 32'(ifc.pc_en), 32'd0);
    tick();

    applyStimulus(32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_pc_en", 32'(ifc.pc_en), 32'd0);
    tick();
    applyStimulus(32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
    checkOutput("stall_br_pc_en", 32'(ifc.pc_en), 32'd1);
    checkOutput("stall_br_pc_addr", ifc.pc_addr, 32'h80);
    checkOutput("stall_br_flush_if", 32'(ifc.flush_if), 32'd1);
    checkOutput("stall_br_flush_id", 32'(ifc.flush_id), 32'd1);
    tick();

    applyStimulus(32'h80, 1'b0, 1'b1, 1'b1, 32'h1003, 1'b0, 32'h0, 1'b0);
    checkOutput("cnt_after_br", 32'(ifc.redirect_cnt), 32'd1);
    checkOutput("jmp_align_addr", ifc.pc_addr, 32'h1000);
    checkOutput("jmp_flush_if", 32'(ifc.flush_if), 32'd1);
    checkOutput("jmp_flush_id", 32'(ifc.flush_id), 32'd0);
    tick();

    applyStimulus(32'h1000, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    checkOutput("prio_pc_addr", ifc.pc_addr, 32'h100);
    checkOutput("prio_flush_id", 32'(ifc.flush_id), 32'd1);
    checkOutput("prio_pc_en", 32'(ifc.pc_en), 32'd1);
    tick();

    applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("cnt_after_3", 32'(ifc.redirect_cnt), 32'd3);
    checkOutput("wrap_pc_addr", ifc.pc_addr, 32'h0);
    tick();

    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h123, 1'b0, 32'h0, 1'b0);
    checkOutput("buf_jmp_pc_en", 32'(ifc.pc_en), 32'd0);
    checkOutput("buf_jmp_flush_id", 32'(ifc.flush_id), 32'd0);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    checkOutput("pend_pending", 32'(ifc.redirect_pending), 32'd1);
    checkOutput("pend_pc_en", 32'(ifc.pc_en), 32'd0);
    checkOutput("pend_br_flush_id", 32'(ifc.flush_id), 32'd1);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    checkOutput("pend_jmp_ignored_fid", 32'(ifc.flush_id), 32'd0);
    checkOutput("pend_jmp_flush_if", 32'(ifc.flush_if), 32'd1);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("pend_apply_pc_en", 32'(ifc.pc_en), 32'd1);
    checkOutput("pend_apply_addr", ifc.pc_addr, 32'h500);
    tick();
    applyStimulus(32'h500, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("pend_cleared", 32'(ifc.redirect_pending), 32'd0);
    checkOutput("after_pend_addr", ifc.pc_addr, 32'h504);
    checkOutput("cnt_saturated", 32'(ifc.redirect_cnt), 32'd3);
    tick();

    applyStimulus(32'h504, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(32'h504, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    checkOutput("pend_exc_addr", ifc.pc_addr, 32'h100);
    checkOutput("pend_exc_flush_id", 32'(ifc.flush_id), 32'd1);
    checkOutput("pend_exc_pc_en", 32'(ifc.pc_en), 32'd1);
    tick();

    applyStimulus(32'h100, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_pc_en", 32'(ifc.pc_en), 32'd0);
    checkOutput("midrst_pc_addr", ifc.pc_addr, 32'h0);
    checkOutput("midrst_pending", 32'(ifc.redirect_pending), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_boot_pc_en", 32'(ifc.pc_en), 32'd0);
    checkOutput("midrst_cnt", 32'(ifc.redirect_cnt), 32'd0);
    checkOutput("midrst_boot_pending", 32'(ifc.redirect_pending), 32'd0);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_first_pc_en", 32'(ifc.pc_en), 32'd1);
    checkOutput("midrst_first_addr", ifc.pc_addr, 32'h4);
    checkOutput("midrst_first_flush_if", 32'(ifc.flush_if), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Next-PC sequencer for the pipelined CPU; drives the PC register's load enable and load address every cycle.
- Arbitrates between sequential fetch (PC+4), the jump target resolved in ID, the branch target resolved in EX and the exception vector.
- Applies hazard stall and instruction-memory readiness, buffers a redirect that cannot be applied immediately, and raises pipeline flush requests.

Parameters:
- RESET_VEC, 32'h00000000, PC value presented during and after reset
- EXC_VEC, 32'h00000100, exception handler entry address
- CNT_W, 16, width of the saturating redirect counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_cur  in  32  current PC register value
- stall  in  1  hazard-unit stall request (load-use)
- imem_ready  in  1  instruction memory can accept a new fetch address this cycle
- jmp  in  1  jump resolved in ID this cycle
- jmp_target  in  32  jump target
- br_taken  in  1  taken branch resolved in EX this cycle
- br_target  in  32  branch target
- exc  in  1  exception raised this cycle
- pc_en  out  1  load enable to the PC register
- pc_addr  out  32  address loaded when pc_en=1
- flush_if  out  1  kill the IF/ID instruction
- flush_id  out  1  kill the ID/EX instruction
- redirect_pending  out  1  a buffered redirect is waiting
- redirect_cnt  out  CNT_W  number of redirects applied, saturating

Behaviour:
- Reset: synchronous, active-high; overrides every other input.
  - While rst=1: state=BOOT, pend_addr=RESET_VEC, pend_kind=NONE, redirect_cnt=0.
  - While rst=1: pc_en=0, pc_addr=RESET_VEC, flush_if=0, flush_id=0, redirect_pending=0.
  - A rst asserted mid-operation discards any pending redirect.
- Outputs: combinational from registered state plus current inputs. A load takes effect on the PC at the same clk edge that samples pc_en=1.
- Alignment: pc_addr[1:0] is always forced to 2'b00.
- Redirect priority: exc > br_taken > jmp. The selected source defines the target and the kind (EXC, BR, JMP).
- Stall rule:
  - stall blocks only sequential advance.
  - A redirect ignores stall, because the stalled instruction is flushed.
  - imem_ready gates every load.
- BOOT: pc_en=0 for exactly one cycle, then RUN. Redirect inputs are ignored in BOOT.
- RUN, no redirect:
  - pc_en = imem_ready & ~stall.
  - pc_addr = pc_cur + 32'd4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
- RUN, redirect present:
  - flush_if=1.
  - flush_id=1 if kind is EXC or BR.
  - If imem_ready=1: pc_en=1, pc_addr=target, remain in RUN, redirect_cnt increments.
  - Otherwise: pc_en=0, latch target into pend_addr and kind into pend_kind, go to PEND.
- PEND:
  - redirect_pending=1 and flush_if=1 every cycle; pc_en=0 until applied.
  - exc overrides the pending redirect of any kind: pend_addr=EXC_VEC and flush_id=1 in that cycle.
  - br_taken overrides only when pend_kind=JMP (the older instruction wins): flush_id=1 in that cycle.
  - jmp is ignored in PEND (wrong-path instruction).
  - When imem_ready=1, load the effective target: a same-cycle override if there is one, else pend_addr. Then pc_en=1, redirect_cnt increments, pend_kind=NONE, go to RUN.
- redirect_cnt:
  - Increments once per applied redirect.
  - Holds at 2^CNT_W-1 when saturated.
- Invariant: the redirect sources never issue a sequential load in the same cycle as a redirect.

Test Plan:
- Reset then run: rst high for 2 cycles; imem_ready=1, stall=0, pc_cur tracks the PC.
  - Expect pc_en=0 in the BOOT cycle.
  - Then pc_addr = 0x4, 0x8, 0xC on consecutive cycles with pc_en=1.
- Stall vs branch:
  - stall=1 with pc_cur=0x40 → pc_en=0.
  - stall=1 with br_taken=1, br_target=0x80 → pc_en=1, pc_addr=0x80, flush_if=1, flush_id=1, redirect_cnt=1.
- Priority: jmp=1 (0x200), br_taken=1 (0x300) and exc=1 asserted in the same cycle → pc_addr=EXC_VEC=0x100, flush_id=1.
- Buffered redirect:
  - jmp=1, jmp_target=0x123 with imem_ready=0 → redirect_pending=1, pc_en=0.
  - Next cycle br_taken=1, br_target=0x500, imem_ready still 0.
  - Then imem_ready=1 → pc_en=1, pc_addr=0x500, redirect_pending drops to 0.
  - In PEND with pend_kind=BR, a jmp is ignored.
- Reset mid-PEND: enter PEND with target 0x700, assert rst for 1 cycle → state BOOT, no load of 0x700, redirect_cnt=0, first sequential address = RESET_VEC+4.
- Wrap and saturation:
  - pc_cur=0xFFFFFFFC with seq advance → pc_addr=0x0.
  - Misaligned jmp_target=0x1003 → pc_addr=0x1000.
  - With CNT_W=2, 5 redirects → redirect_cnt=3.
